// File: rtl/pool2x2_stage.sv
// Streaming 2x2 stride-2 signed max-pool with a one-row line buffer and valid/ready on both sides.
// Optional build macro POOL2X2_RELU_EN clamps negative pooled results to zero on output.
module pool2x2_stage #(
  parameter int W  = 10,
  parameter int H  = 10,
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam int RW = (H > 2) ? $clog2(H) : 1;
  localparam int LW = (W > 2) ? $clog2(W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nx;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] idx;
  logic signed [DW-1:0] h_reg;
  logic signed [DW-1:0] lbuf [0:W/2-1];

  logic                 acc;
  logic                 load;
  logic                 last_px;
  logic [LW-1:0]        lidx;
  logic signed [DW-1:0] pix;
  logic signed [DW-1:0] hmax;
  logic signed [DW-1:0] lval;
  logic signed [DW-1:0] pool;
  logic signed [DW-1:0] pool_out;

  // out_ready feeds in_ready combinationally so a single output register sustains full rate
  assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign load     = acc && col[0] && row[0];
  assign last_px  = acc && (col == COL_LAST) && (row == ROW_LAST);
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);
  assign lidx     = LW'(col >> 1);
  assign pix      = $signed(in_data);

  always_comb begin
    hmax = (pix > h_reg) ? pix : h_reg;
    lval = lbuf[lidx];
    pool = (lval > hmax) ? lval : hmax;
`ifdef POOL2X2_RELU_EN
    pool_out = pool[DW-1] ? '0 : pool;
`else
    pool_out = pool;
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last_px) state_nx = S_DRAIN;
      S_DRAIN: if (!out_valid || out_ready) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      idx       <= '0;
      h_reg     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start) begin
        col <= '0;
        row <= '0;
        idx <= '0;
      end else if (acc) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (!col[0]) h_reg <= pix;
      end
      // a fresh load wins over a same-cycle handshake, keeping out_valid high
      if (load) begin
        out_data  <= pool_out;
        out_addr  <= idx;
        out_valid <= 1'b1;
        idx       <= idx + AW'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset is needed
  always_ff @(posedge clk) begin
    if (acc && col[0] && !row[0]) lbuf[lidx] <= hmax;
  end

endmodule

// File: tb/tb_pool2x2_stage.sv
// Randomized self-checking bench for pool2x2_stage against a window-maximum reference model.
module tb_pool2x2_stage;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_ready;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  pool2x2_stage #(.W(W), .H(H), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt;
  logic signed [DW-1:0] pix [N];
  exp_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  task automatic build_model();
    exp_q.delete();
    for (int r = 0; r < H / 2; r++) begin
      for (int c = 0; c < W / 2; c++) begin
        logic signed [DW-1:0] m;
        m = smax(smax(pix[2*r*W + 2*c], pix[2*r*W + 2*c + 1]),
                 smax(pix[(2*r+1)*W + 2*c], pix[(2*r+1)*W + 2*c + 1]));
`ifdef POOL2X2_RELU_EN
        if (m < 0) m = '0;
`endif
        exp_q.push_back('{a: AW'(r * (W / 2) + c), d: m});
      end
    end
  endtask

  task automatic check_reset_vals();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_addr", out_addr, 0);
  endtask

  // vmode: 0 always valid, 1 alternating, 2 random; rmode: 0 always ready, 1 five-cycle stall, 2 random
  task automatic run_frame(input int vmode, input int rmode, input bit sflag, input int abort_at);
    int p = 0, cyc = 0, first_acc = -1, last_acc = -1, stall_left = 0;
    bit stall_started = 0, prev_hold = 0, done_seen = 0, aborted = 0;
    logic [DW-1:0] hold_d;
    logic [AW-1:0] hold_a;
    exp_t e;
    done_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done_seen && cyc < 3000) begin
      if (abort_at > 0 && p == abort_at) begin
        in_valid = 1'b0;
        aborted = 1;
        break;
      end
      in_valid = (p < N) && ((vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom));
      in_data  = (p < N) ? pix[p] : DW'($urandom);
      if (rmode == 1) begin
        if (!stall_started && out_valid) begin
          stall_started = 1;
          stall_left = 5;
        end
        out_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        out_ready = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      start = sflag && busy && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_d);
        check("hold_addr", out_addr, hold_a);
      end
      if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
      prev_hold = out_valid && !out_ready;
      hold_d = out_data;
      hold_a = out_addr;
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        p++;
      end
      if (out_valid && out_ready) begin
        check("out_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_addr", out_addr, e.a);
          check("out_data", out_data, e.d);
        end
      end
      if (done) begin
        done_cnt++;
        done_seen = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (aborted) return;
    check("done_count", done_cnt, 1);
    check("outs_left", exp_q.size(), 0);
    check("pixels_acc", p, N);
    if (vmode == 0 && rmode == 0) check("full_rate_span", last_acc - first_acc, N - 1);
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_in_ready", in_ready, 0);
      check("idle_done", done, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic basic_pixels();
    for (int i = 0; i < N; i++) pix[i] = DW'(i);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst = 1'b0;

    basic_pixels();
    build_model();
    run_frame(0, 0, 0, 0);

    for (int i = 0; i < N; i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      pix[i] = (r % 2 == 0) ? ((c % 2 == 0) ? -8 : -3) : ((c % 2 == 0) ? -5 : -120);
    end
    build_model();
    run_frame(0, 0, 0, 0);

    basic_pixels();
    build_model();
    run_frame(0, 1, 0, 0);

    build_model();
    run_frame(1, 0, 0, 0);

    build_model();
    run_frame(0, 0, 0, 9);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    check("abort_no_done", done_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    build_model();
    run_frame(0, 0, 0, 0);

    build_model();
    run_frame(2, 2, 1, 0);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) pix[i] = DW'($urandom);
      build_model();
      run_frame(2, 2, 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
